// File: rtl/ows_rom_seq.sv
// 1-Wire slave ROM-layer sequencer: takes the ROM command after each bus reset
// and runs READ/MATCH/SKIP/SEARCH ROM against the device UID.
module ows_rom_seq #(
    parameter logic [7:0] CMD_READ_ROM   = 8'h33,
    parameter logic [7:0] CMD_MATCH_ROM  = 8'h55,
    parameter logic [7:0] CMD_SKIP_ROM   = 8'hCC,
    parameter logic [7:0] CMD_SEARCH_ROM = 8'hF0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_flag,
    input  logic        rx_bit_valid,
    input  logic        rx_bit,
    input  logic        tx_rdy,
    output logic        tx_valid,
    output logic        tx_bit,
    input  logic [63:0] uid,
    output logic        snd_prsnc,
    output logic [7:0]  rom_cmd,
    output logic        cmd_valid,
    output logic        selected,
    output logic        cmd_err
);

    localparam int unsigned IDX_W = 6;
    localparam int unsigned CMD_W = 8;

    typedef enum logic [3:0] {
        IDLE, PRESENCE, GET_CMD, DISPATCH, READ_TX,
        MATCH_RX, SRCH_TX_T, SRCH_TX_C, SRCH_RX, FUNC
    } state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [CMD_W-1:0]   sr, sr_d;
    logic [CMD_W-1:0]   rom_cmd_d;
    logic               cmd_valid_d, cmd_err_d;
    logic               tx_valid_d, tx_bit_d, snd_prsnc_d, selected_d;
    logic               last_bit, tx_xfer, uid_bit;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            sr        <= '0;
            rom_cmd   <= '0;
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            tx_valid  <= 1'b0;
            tx_bit    <= 1'b0;
            snd_prsnc <= 1'b0;
            selected  <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            sr        <= sr_d;
            rom_cmd   <= rom_cmd_d;
            cmd_valid <= cmd_valid_d;
            cmd_err   <= cmd_err_d;
            tx_valid  <= tx_valid_d;
            tx_bit    <= tx_bit_d;
            snd_prsnc <= snd_prsnc_d;
            selected  <= selected_d;
        end
    end

    // Next state, counters and next output values
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        sr_d        = sr;
        rom_cmd_d   = rom_cmd;
        cmd_valid_d = 1'b0;
        cmd_err_d   = cmd_err;
        last_bit    = (idx == IDX_W'(63));
        tx_xfer     = tx_valid & tx_rdy;
        uid_bit     = uid[idx];

        if (start_flag) begin
            state_d   = PRESENCE;
            idx_d     = '0;
            sr_d      = '0;
            cmd_err_d = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                PRESENCE: begin
                    state_d = GET_CMD;
                    idx_d   = '0;
                end
                GET_CMD: begin
                    if (rx_bit_valid) begin
                        sr_d = {rx_bit, sr[CMD_W-1:1]};
                        if (idx == IDX_W'(CMD_W - 1)) begin
                            rom_cmd_d   = sr_d;
                            cmd_valid_d = 1'b1;
                            idx_d       = '0;
                            state_d     = DISPATCH;
                        end else begin
                            idx_d = idx + IDX_W'(1);
                        end
                    end
                end
                DISPATCH: begin
                    idx_d = '0;
                    case (rom_cmd)
                        CMD_READ_ROM:   state_d = READ_TX;
                        CMD_MATCH_ROM:  state_d = MATCH_RX;
                        CMD_SEARCH_ROM: state_d = SRCH_TX_T;
                        CMD_SKIP_ROM:   state_d = FUNC;
                        default: begin
                            cmd_err_d = 1'b1;
                            state_d   = IDLE;
                        end
                    endcase
                end
                READ_TX: begin
                    if (tx_xfer) begin
                        if (last_bit) state_d = FUNC;
                        else          idx_d   = idx + IDX_W'(1);
                    end
                end
                MATCH_RX: begin
                    if (rx_bit_valid) begin
                        if (rx_bit != uid_bit) state_d = IDLE;
                        else if (last_bit)     state_d = FUNC;
                        else                   idx_d   = idx + IDX_W'(1);
                    end
                end
                SRCH_TX_T: if (tx_xfer) state_d = SRCH_TX_C;
                SRCH_TX_C: if (tx_xfer) state_d = SRCH_RX;
                SRCH_RX: begin
                    if (rx_bit_valid) begin
                        if (rx_bit != uid_bit) state_d = IDLE;
                        else if (last_bit)     state_d = FUNC;
                        else begin
                            idx_d   = idx + IDX_W'(1);
                            state_d = SRCH_TX_T;
                        end
                    end
                end
                FUNC: ;
                default: state_d = IDLE;
            endcase
        end

        // Outputs follow the upcoming state so they line up with it
        tx_valid_d  = (state_d == READ_TX) || (state_d == SRCH_TX_T) || (state_d == SRCH_TX_C);
        tx_bit_d    = tx_valid_d & (uid[idx_d] ^ (state_d == SRCH_TX_C));
        snd_prsnc_d = (state_d == PRESENCE);
        selected_d  = (state_d == FUNC);
    end

endmodule

// File: tb/tb_ows_rom_seq.sv
// Self-checking bench for ows_rom_seq: scoreboarded ROM command and tx bit streams.
module tb_ows_rom_seq;

    localparam logic [63:0] UID = 64'hA500001234567828;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_flag, rx_bit_valid, rx_bit, tx_rdy;
    logic        tx_valid, tx_bit, snd_prsnc, cmd_valid, selected, cmd_err;
    logic [7:0]  rom_cmd;
    logic [63:0] uid;

    int errors = 0;
    int checks = 0;
    logic       exp_q[$];
    logic [7:0] cmd_q[$];

    always #5 clk = ~clk;

    ows_rom_seq dut (
        .clk(clk), .rst_n(rst_n), .start_flag(start_flag),
        .rx_bit_valid(rx_bit_valid), .rx_bit(rx_bit), .tx_rdy(tx_rdy),
        .tx_valid(tx_valid), .tx_bit(tx_bit), .uid(uid),
        .snd_prsnc(snd_prsnc), .rom_cmd(rom_cmd), .cmd_valid(cmd_valid),
        .selected(selected), .cmd_err(cmd_err)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start();
        start_flag = 1'b1;
        tick();
        start_flag = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        rx_bit_valid = 1'b1;
        rx_bit       = b;
        tick();
        rx_bit_valid = 1'b0;
        rx_bit       = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        cmd_q.push_back(c);
        for (int i = 0; i < 8; i++) send_bit(c[i]);
    endtask

    task automatic test_reset();
        logic [14:0] outs;
        rst_n = 1'b0; start_flag = 0; rx_bit_valid = 0; rx_bit = 0; tx_rdy = 0;
        uid = UID;
        #1;
        outs = {tx_valid, tx_bit, snd_prsnc, rom_cmd, cmd_valid, selected, cmd_err};
        checks++;
        if (outs !== 15'h0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_rdy = 1'b1; rx_bit_valid = 1'b1;
            tick();
            checks++;
            if (tx_valid !== 1'b0 || snd_prsnc !== 1'b0) begin
                errors++; $display("FAIL idle_quiet: tx_valid=%b snd_prsnc=%b expected 0 0", tx_valid, snd_prsnc);
            end
        end
        tx_rdy = 0; rx_bit_valid = 0;
    endtask

    task automatic test_read_rom();
        logic [7:0] ec;
        logic       eb;
        int n = 0, cyc = 0;
        do_start();
        checks++;
        if (snd_prsnc !== 1'b1) begin errors++; $display("FAIL presence_pulse: got %b expected 1", snd_prsnc); end
        tick();
        checks++;
        if (snd_prsnc !== 1'b0) begin errors++; $display("FAIL presence_single: got %b expected 0", snd_prsnc); end
        send_cmd(8'h33);
        ec = cmd_q.pop_front();
        checks++;
        if (cmd_valid !== 1'b1 || rom_cmd !== ec) begin
            errors++; $display("FAIL read_cmd: cmd_valid=%b rom_cmd=%h expected 1 %h", cmd_valid, rom_cmd, ec);
        end
        for (int i = 0; i < 64; i++) exp_q.push_back(UID[i]);
        tick();
        while (n < 64 && cyc < 1000) begin
            tx_rdy = 1'($urandom_range(0, 1));
            if (tx_valid === 1'b1 && tx_rdy) begin
                eb = exp_q.pop_front();
                checks++;
                if (tx_bit !== eb) begin
                    errors++; $display("FAIL read_bit[%0d]: got %b expected %b", n, tx_bit, eb);
                end
                n++;
            end
            tick();
            cyc++;
        end
        tx_rdy = 1'b0;
        checks++;
        if (n != 64) begin errors++; $display("FAIL read_timeout: got %0d bits expected 64", n); end
        checks++;
        if (selected !== 1'b1 || tx_valid !== 1'b0) begin
            errors++; $display("FAIL read_select: selected=%b tx_valid=%b expected 1 0", selected, tx_valid);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_read();
        logic [14:0] outs;
        do_start(); tick();
        send_cmd(8'h33);
        void'(cmd_q.pop_front());
        tick();
        tx_rdy = 1'b1;
        repeat (20) tick();
        tx_rdy = 1'b0;
        checks++;
        if (tx_valid !== 1'b1) begin errors++; $display("FAIL midread_active: got %b expected 1", tx_valid); end
        rst_n = 1'b0;
        #1;
        outs = {tx_valid, tx_bit, snd_prsnc, rom_cmd, cmd_valid, selected, cmd_err};
        checks++;
        if (outs !== 15'h0) begin errors++; $display("FAIL midread_reset: got %h expected 0", outs); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_rdy = 1'b1; rx_bit_valid = 1'(i % 2);
            tick();
            checks++;
            if (tx_valid !== 1'b0 || selected !== 1'b0) begin
                errors++; $display("FAIL midread_idle: tx_valid=%b selected=%b expected 0 0", tx_valid, selected);
            end
        end
        tx_rdy = 0; rx_bit_valid = 0;
    endtask

    task automatic test_match_rom();
        logic [63:0] bad;
        logic [7:0]  ec;
        bad = UID ^ (64'd1 << 40);
        for (int pass = 0; pass < 2; pass++) begin
            do_start(); tick();
            send_cmd(8'h55);
            ec = cmd_q.pop_front();
            checks++;
            if (cmd_valid !== 1'b1 || rom_cmd !== ec) begin
                errors++; $display("FAIL match_cmd: cmd_valid=%b rom_cmd=%h expected 1 %h", cmd_valid, rom_cmd, ec);
            end
            tick();
            for (int i = 0; i < 64; i++) begin
                send_bit(pass == 0 ? bad[i] : UID[i]);
                checks++;
                if (tx_valid !== 1'b0) begin errors++; $display("FAIL match_tx[%0d]: got %b expected 0", i, tx_valid); end
            end
            checks++;
            if (selected !== 1'(pass)) begin
                errors++; $display("FAIL match_select pass%0d: got %b expected %0d", pass, selected, pass);
            end
        end
    endtask

    task automatic test_search_rom(input int abort_at);
        logic [7:0] ec;
        logic       eb;
        int w;
        bit aborted = 0;
        do_start(); tick();
        send_cmd(8'hF0);
        ec = cmd_q.pop_front();
        checks++;
        if (cmd_valid !== 1'b1 || rom_cmd !== ec) begin
            errors++; $display("FAIL search_cmd: cmd_valid=%b rom_cmd=%h expected 1 %h", cmd_valid, rom_cmd, ec);
        end
        tick();
        for (int i = 0; i < 64 && !aborted; i++) begin
            exp_q.push_back(UID[i]);
            exp_q.push_back(~UID[i]);
            for (int k = 0; k < 2; k++) begin
                repeat ($urandom_range(0, 2)) tick();
                w = 0;
                while (tx_valid !== 1'b1 && w < 20) begin tick(); w++; end
                eb = exp_q.pop_front();
                checks++;
                if (tx_valid !== 1'b1 || tx_bit !== eb) begin
                    errors++; $display("FAIL search_bit[%0d.%0d]: valid=%b bit=%b expected 1 %b", i, k, tx_valid, tx_bit, eb);
                end
                tx_rdy = 1'b1;
                tick();
                tx_rdy = 1'b0;
            end
            checks++;
            if (tx_valid !== 1'b0) begin errors++; $display("FAIL search_rx_wait[%0d]: got %b expected 0", i, tx_valid); end
            if (i == abort_at) begin
                send_bit(~UID[i]);
                aborted = 1;
            end else begin
                send_bit(UID[i]);
            end
        end
        if (aborted) begin
            for (int c = 0; c < 20; c++) begin
                tx_rdy = 1'b1;
                tick();
                checks++;
                if (tx_valid !== 1'b0 || selected !== 1'b0) begin
                    errors++; $display("FAIL search_abort: tx_valid=%b selected=%b expected 0 0", tx_valid, selected);
                end
            end
            tx_rdy = 1'b0;
        end else begin
            checks++;
            if (selected !== 1'b1) begin errors++; $display("FAIL search_select: got %b expected 1", selected); end
        end
        exp_q.delete();
    endtask

    task automatic test_skip_and_err();
        logic [7:0] ec;
        do_start(); tick();
        send_cmd(8'hCC);
        ec = cmd_q.pop_front();
        checks++;
        if (cmd_valid !== 1'b1 || rom_cmd !== ec || selected !== 1'b0) begin
            errors++; $display("FAIL skip_cmd: cmd_valid=%b rom_cmd=%h selected=%b expected 1 %h 0", cmd_valid, rom_cmd, selected, ec);
        end
        tick();
        checks++;
        if (selected !== 1'b1 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL skip_select: selected=%b cmd_valid=%b expected 1 0", selected, cmd_valid);
        end
        do_start();
        checks++;
        if (selected !== 1'b0) begin errors++; $display("FAIL start_deselect: got %b expected 0", selected); end
        tick();
        send_cmd(8'h99);
        ec = cmd_q.pop_front();
        checks++;
        if (cmd_valid !== 1'b1 || rom_cmd !== ec) begin
            errors++; $display("FAIL err_cmd: cmd_valid=%b rom_cmd=%h expected 1 %h", cmd_valid, rom_cmd, ec);
        end
        tick();
        checks++;
        if (cmd_err !== 1'b1 || selected !== 1'b0) begin
            errors++; $display("FAIL err_flag: cmd_err=%b selected=%b expected 1 0", cmd_err, selected);
        end
        for (int i = 0; i < 8; i++) send_bit(i[0]);
        tx_rdy = 1'b1; tick(); tx_rdy = 1'b0;
        checks++;
        if (cmd_err !== 1'b1 || selected !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL err_hold: cmd_err=%b selected=%b cmd_valid=%b expected 1 0 0", cmd_err, selected, cmd_valid);
        end
        do_start();
        checks++;
        if (cmd_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", cmd_err); end
        tick();
    endtask

    task automatic test_start_abort();
        logic [7:0] ec;
        do_start(); tick();
        send_cmd(8'h55);
        void'(cmd_q.pop_front());
        tick();
        for (int i = 0; i < 30; i++) send_bit(UID[i]);
        start_flag = 1'b1; rx_bit_valid = 1'b1; rx_bit = UID[30];
        tick();
        start_flag = 1'b0; rx_bit_valid = 1'b0; rx_bit = 1'b0;
        checks++;
        if (snd_prsnc !== 1'b1 || selected !== 1'b0) begin
            errors++; $display("FAIL abort_presence: snd_prsnc=%b selected=%b expected 1 0", snd_prsnc, selected);
        end
        tick();
        checks++;
        if (snd_prsnc !== 1'b0) begin errors++; $display("FAIL abort_presence_end: got %b expected 0", snd_prsnc); end
        send_cmd(8'hCC);
        ec = cmd_q.pop_front();
        checks++;
        if (cmd_valid !== 1'b1 || rom_cmd !== ec) begin
            errors++; $display("FAIL abort_fresh_cmd: cmd_valid=%b rom_cmd=%h expected 1 %h", cmd_valid, rom_cmd, ec);
        end
        tick();
        checks++;
        if (selected !== 1'b1) begin errors++; $display("FAIL abort_skip_select: got %b expected 1", selected); end
    endtask

    initial begin
        test_reset();
        test_read_rom();
        test_reset_mid_read();
        test_match_rom();
        test_search_rom(64);
        test_search_rom(5);
        test_skip_and_err();
        test_start_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ows_rom_seq.md
Name: ows_rom_seq

Overview:
ROM-layer sequencer for the 1-Wire slave. It sits between the bit-level read/write line interfaces and the function-command logic. After each reset/presence cycle it receives the 8-bit ROM command and executes READ ROM, MATCH ROM, SKIP ROM or SEARCH ROM against the 64-bit device UID. It then either enables the function layer or drops the slave off the bus until the next bus reset.

Parameters:
CMD_READ_ROM, 8'h33, READ ROM opcode
CMD_MATCH_ROM, 8'h55, MATCH ROM opcode
CMD_SKIP_ROM, 8'hCC, SKIP ROM opcode
CMD_SEARCH_ROM, 8'hF0, SEARCH ROM opcode

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_flag  in  1  one-cycle pulse: bus reset pulse detected
rx_bit_valid  in  1  one-cycle pulse: master write slot sampled
rx_bit  in  1  sampled bit, valid with rx_bit_valid
tx_rdy  in  1  write interface accepts tx_bit this cycle (read slot consumed)
tx_valid  out  1  bit available for the next master read slot
tx_bit  out  1  bit to drive in the read slot
uid  in  64  device ROM ID (family code in [7:0], CRC in [63:56]); static
snd_prsnc  out  1  one-cycle pulse: request presence pulse
rom_cmd  out  8  last received ROM command
cmd_valid  out  1  one-cycle pulse: rom_cmd updated
selected  out  1  device addressed; function layer owns the bus
cmd_err  out  1  unknown ROM command received; held until start_flag

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low. Reset drives every output to 0, state to IDLE, and clears the counters.
- States: IDLE, PRESENCE, GET_CMD, DISPATCH, READ_TX, MATCH_RX, SRCH_TX_T, SRCH_TX_C, SRCH_RX, FUNC.
- start_flag in any state: next state PRESENCE. It clears selected, cmd_err, bit index idx[5:0] and the shift register, and aborts any transfer in progress. It has priority over a simultaneous rx_bit_valid or tx_rdy; that bit is discarded.
- PRESENCE: snd_prsnc = 1 for exactly one cycle, then GET_CMD.
- GET_CMD: on each rx_bit_valid, shift the bit in LSB first. On the 8th bit, latch rom_cmd, pulse cmd_valid in the same cycle, and go to DISPATCH.
- DISPATCH (1 cycle), decoded by rom_cmd:
  - READ -> READ_TX.
  - MATCH -> MATCH_RX.
  - SEARCH -> SRCH_TX_T.
  - SKIP -> FUNC.
  - Any other value -> cmd_err = 1, then IDLE.
  - idx = 0 on entry to every branch.
- READ_TX: tx_valid = 1 with tx_bit = uid[idx]. On tx_valid & tx_rdy, idx++. When the transfer at idx = 63 completes -> FUNC.
- MATCH_RX: on rx_bit_valid, compare rx_bit with uid[idx].
  - Mismatch -> IDLE (deselected; all further slots ignored).
  - Match with idx = 63 -> FUNC.
  - Match otherwise -> idx++.
- SEARCH ROM triplet for each idx:
  - SRCH_TX_T sends uid[idx].
  - SRCH_TX_C sends ~uid[idx].
  - SRCH_RX waits for rx_bit_valid. rx_bit != uid[idx] -> IDLE. Equal with idx = 63 -> FUNC. Equal otherwise -> idx++ and back to SRCH_TX_T.
- FUNC: selected = 1 and held. The block ignores all rx/tx activity until start_flag.
- IDLE: tx_valid = 0; rx_bit_valid and tx_rdy are ignored.
- Handshake rules:
  - tx_valid and tx_bit stay stable until accepted. Transfer happens on a cycle with tx_valid & tx_rdy.
  - tx_valid = 0 in every non-TX state.
  - tx_rdy while tx_valid = 0 has no effect.
  - rx_bit_valid in TX states is ignored, and does not advance idx.
- Latency:
  - DISPATCH adds 1 cycle after the 8th command bit.
  - The next tx_valid is asserted the cycle after the previous transfer.
- idx never wraps: every transition at idx = 63 exits the loop.

Test Plan:
- Reset mid-READ_TX (rst_n low at idx = 20) -> all outputs 0 immediately; after release, state IDLE and tx_valid = 0 until start_flag.
- start_flag, then rx bits of 0x33 LSB first, uid = 64'hA5_0000_1234_5678_28 pattern -> snd_prsnc one pulse; cmd_valid with rom_cmd = 8'h33; 64 tx bits equal to uid[0..63] with random tx_rdy gaps; then selected = 1.
- Command 0x55 followed by uid with bit 40 flipped -> tx_valid never set; selected stays 0 after all 64 bits. Repeat with exact uid -> selected = 1 after the 64th rx bit.
- Command 0xF0 with the master always answering uid[idx] -> 64 triplets each observed as (uid[i], ~uid[i]), then selected = 1. Answer ~uid[5] at idx 5 -> IDLE, and no further tx_valid.
- Command 0xCC -> selected = 1 two cycles after the 8th bit. Command 0x99 -> cmd_err = 1 and selected = 0; both persist until the next start_flag, which clears cmd_err.
- start_flag coincident with rx_bit_valid during MATCH_RX at idx = 30 -> bit discarded; snd_prsnc pulses next cycle; the following 8 bits are treated as a fresh command.
